// File: rtl/rca_multiword_seq.sv
// rca_multiword_seq: adds two N*WORDS-bit operands by stepping an external
// combinational N-bit ripple-carry adder over one slice per clock, LSB first.
// The carry is chained through a register and the partial sums are assembled
// into the full result.
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; A_in, B_in, C_in captured on accept
//   rca_A/rca_B/rca_cin   slice drive to the external adder (zero outside RUN)
//   rca_s/rca_cout        slice sum and carry returned by the external adder
//   out_valid/out_ready   result handshake; S_out, C_out held while out_valid
module rca_multiword_seq #(
   parameter int unsigned N     = 5,
   parameter int unsigned WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*WORDS-1:0]   A_in,
   input  logic [N*WORDS-1:0]   B_in,
   input  logic                 C_in,
   output logic [N-1:0]         rca_A,
   output logic [N-1:0]         rca_B,
   output logic                 rca_cin,
   input  logic [N-1:0]         rca_s,
   input  logic                 rca_cout,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*WORDS-1:0]   S_out,
   output logic                 C_out
);

   localparam int unsigned W     = N * WORDS;
   // At least one index bit so WORDS=1 still has a legal counter.
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q,     state_d;
   logic [IDX_W-1:0] idx_q,       idx_d;
   logic [W-1:0]     a_q,         a_d;
   logic [W-1:0]     b_q,         b_d;
   logic [W-1:0]     s_q,         s_d;
   logic             carry_q,     carry_d;
   logic [N-1:0]     rca_a_q,     rca_a_d;
   logic [N-1:0]     rca_b_q,     rca_b_d;
   logic             rca_cin_q,   rca_cin_d;
   logic             out_valid_q, out_valid_d;
   logic [IDX_W-1:0] nxt_idx;

   // Next-state logic; the adder drive is registered one slice ahead so the
   // pins come straight from flops during each RUN cycle.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      a_d         = a_q;
      b_d         = b_q;
      s_d         = s_q;
      carry_d     = carry_q;
      out_valid_d = out_valid_q;
      rca_a_d     = '0;
      rca_b_d     = '0;
      rca_cin_d   = 1'b0;
      nxt_idx     = idx_q + IDX_W'(1);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d       = A_in;
               b_d       = B_in;
               carry_d   = C_in;
               idx_d     = '0;
               rca_a_d   = A_in[N-1:0];
               rca_b_d   = B_in[N-1:0];
               rca_cin_d = C_in;
               state_d   = RUN;
            end
         end
         RUN: begin
            s_d[32'(idx_q)*N +: N] = rca_s;
            carry_d                = rca_cout;
            if (idx_q == LAST_IDX) begin
               idx_d       = '0;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               idx_d     = nxt_idx;
               rca_a_d   = N'(a_q >> (32'(nxt_idx) * N));
               rca_b_d   = N'(b_q >> (32'(nxt_idx) * N));
               rca_cin_d = rca_cout;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         carry_q     <= 1'b0;
         rca_a_q     <= '0;
         rca_b_q     <= '0;
         rca_cin_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         a_q         <= a_d;
         b_q         <= b_d;
         s_q         <= s_d;
         carry_q     <= carry_d;
         rca_a_q     <= rca_a_d;
         rca_b_q     <= rca_b_d;
         rca_cin_q   <= rca_cin_d;
         out_valid_q <= out_valid_d;
      end
   end

   // in_ready is held low while reset is applied, not just after it.
   assign in_ready  = rst_n & (state_q == IDLE);
   assign rca_A     = rca_a_q;
   assign rca_B     = rca_b_q;
   assign rca_cin   = rca_cin_q;
   assign out_valid = out_valid_q;
   assign S_out     = s_q;
   assign C_out     = carry_q;

endmodule

// File: tb/tb_rca_multiword_seq.sv
// Testbench for rca_multiword_seq: a 4-slice instance and a 1-slice instance,
// each attached to a behavioural N-bit adder, checked against whole-word sums.
module tb_rca_multiword_seq;

   localparam int unsigned N  = 5;
   localparam int unsigned WD = 4;
   localparam int unsigned W  = N * WD;

   logic clk;
   logic rst_n;

   // 4-slice instance
   logic         in_valid, in_ready, C_in, rca_cin, rca_cout, out_valid, out_ready, C_out;
   logic [W-1:0] A_in, B_in, S_out;
   logic [N-1:0] rca_A, rca_B, rca_s;

   // 1-slice instance
   logic         in_valid1, in_ready1, C_in1, rca_cin1, rca_cout1, out_valid1, out_ready1, C_out1;
   logic [N-1:0] A_in1, B_in1, S_out1;
   logic [N-1:0] rca_A1, rca_B1, rca_s1;

   int checks;
   int errors;

   // External combinational adders
   assign {rca_cout, rca_s}   = 6'(rca_A)  + 6'(rca_B)  + 6'(rca_cin);
   assign {rca_cout1, rca_s1} = 6'(rca_A1) + 6'(rca_B1) + 6'(rca_cin1);

   rca_multiword_seq #(.N(N), .WORDS(WD)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .A_in(A_in), .B_in(B_in), .C_in(C_in),
      .rca_A(rca_A), .rca_B(rca_B), .rca_cin(rca_cin),
      .rca_s(rca_s), .rca_cout(rca_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .S_out(S_out), .C_out(C_out)
   );

   rca_multiword_seq #(.N(N), .WORDS(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .A_in(A_in1), .B_in(B_in1), .C_in(C_in1),
      .rca_A(rca_A1), .rca_B(rca_B1), .rca_cin(rca_cin1),
      .rca_s(rca_s1), .rca_cout(rca_cout1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .S_out(S_out1), .C_out(C_out1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One full operation on the 4-slice instance; hold = cycles of out_ready=0
   // after out_valid. Carry into each slice is derived from the whole sum:
   // carry into bit i equals (sum ^ a ^ b)[i].
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input int hold, input string tag);
      logic [W:0]    exp_sum;
      logic [W:0]    carries;
      logic [WD-1:0] cin_seen;
      logic [WD-1:0] cin_exp;
      int            k;
      exp_sum  = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
      carries  = exp_sum ^ (W+1)'(a) ^ (W+1)'(b);
      for (int i = 0; i < int'(WD); i++) cin_exp[i] = carries[i*N];
      cin_seen = '0;

      @(negedge clk);
      check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; A_in = a; B_in = b; C_in = c;
      @(negedge clk);
      // Scramble inputs after acceptance; the registered copy must be used.
      in_valid = 1'b0; A_in = W'($urandom); B_in = W'($urandom); C_in = 1'($urandom);
      check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
      check({tag, "_rca_A0"}, 32'(rca_A), 32'(a[N-1:0]));
      check({tag, "_rca_B0"}, 32'(rca_B), 32'(b[N-1:0]));
      k = 0;
      while (!out_valid && k < 20) begin
         if (k < int'(WD)) cin_seen[k] = rca_cin;
         @(negedge clk);
         k++;
      end
      check({tag, "_latency"}, 32'(k), 32'(WD));
      check({tag, "_rca_cin_seq"}, 32'(cin_seen), 32'(cin_exp));
      check({tag, "_S_out"}, 32'(S_out), 32'(exp_sum[W-1:0]));
      check({tag, "_C_out"}, 32'(C_out), 32'(exp_sum[W]));
      check({tag, "_rca_A_done"}, 32'(rca_A), 32'd0);

      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1; A_in = ~a; B_in = ~b; C_in = ~c;
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
         check({tag, "_hold_S_out"}, 32'(S_out), 32'(exp_sum[W-1:0]));
         check({tag, "_hold_C_out"}, 32'(C_out), 32'(exp_sum[W]));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   // One operation on the 1-slice instance.
   task automatic run_op1(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                          input string tag);
      logic [N:0] exp_sum;
      exp_sum = (N+1)'(a) + (N+1)'(b) + (N+1)'(c);
      @(negedge clk);
      in_valid1 = 1'b1; A_in1 = a; B_in1 = b; C_in1 = c;
      @(negedge clk);
      in_valid1 = 1'b0; A_in1 = N'($urandom); B_in1 = N'($urandom);
      check({tag, "_run_valid"}, 32'(out_valid1), 32'd0);
      check({tag, "_rca_A"}, 32'(rca_A1), 32'(a));
      check({tag, "_rca_cin"}, 32'(rca_cin1), 32'(c));
      @(negedge clk);
      check({tag, "_valid"}, 32'(out_valid1), 32'd1);
      check({tag, "_S_out"}, 32'(S_out1), 32'(exp_sum[N-1:0]));
      check({tag, "_C_out"}, 32'(C_out1), 32'(exp_sum[N]));
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      check({tag, "_release_valid"}, 32'(out_valid1), 32'd0);
   endtask

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0;
      in_valid = 1'b0; A_in = '0; B_in = '0; C_in = 1'b0; out_ready = 1'b0;
      in_valid1 = 1'b0; A_in1 = '0; B_in1 = '0; C_in1 = 1'b0; out_ready1 = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_S_out", 32'(S_out), 32'd0);
      check("rst_C_out", 32'(C_out), 32'd0);
      check("rst_rca", 32'({rca_A, rca_B, rca_cin}), 32'd0);
      check("rst1_out_valid", 32'(out_valid1), 32'd0);
      check("rst1_in_ready", 32'(in_ready1), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle1_in_ready", 32'(in_ready1), 32'd1);

      // Directed cases
      run_op(20'h00005, 20'h0000F, 1'b1, 0, "basic");
      run_op(20'hFFFFF, 20'h00000, 1'b1, 0, "ripple");
      run_op(20'hFFFFF, 20'hFFFFF, 1'b0, 0, "max");
      run_op(20'h3A5C1, 20'h1234F, 1'b1, 5, "backpressure");

      // Reset during RUN cycle 2
      @(negedge clk);
      in_valid = 1'b1; A_in = 20'hFFFFF; B_in = 20'hFFFFF; C_in = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("midrun_rca_A1", 32'(rca_A), 32'h1F);
      rst_n = 1'b0;
      #1;
      check("midrun_out_valid", 32'(out_valid), 32'd0);
      check("midrun_rca", 32'({rca_A, rca_B, rca_cin}), 32'd0);
      check("midrun_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("postrst_no_valid", 32'(out_valid), 32'd0);
      end
      run_op(20'h00001, 20'h00001, 1'b0, 0, "postrst");

      // Randomized operations against the whole-word model
      for (int i = 0; i < 25; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rand");
      end

      // Single-slice configuration
      run_op1(5'b11111, 5'b11111, 1'b0, "w1_max");
      for (int i = 0; i < 8; i++) begin
         run_op1(N'($urandom), N'($urandom), 1'($urandom), "w1_rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
